game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Initiator side of the 16-cell board's command interface.
- Issues one-hot move requests on the board's ready_from_global lines and waits for the matching board_done pulse.
- After a move, compares the 64-bit board state against a pre-move snapshot and spawns a new tile into an empty cell through the preset port (preset_ext / preset_location / value_from_preset).
- Also seeds the starting tiles and flags win, game-over and handshake timeout to the top level.

Parameters:
- LFSR_SEED, 16'hACE1: reset value of the 16-bit Galois LFSR. Must be nonzero.
- START_TILES, 2: number of tiles spawned after start.
- DONE_TIMEOUT, 255: cycles to wait for board_done before aborting a move.
- WIN_VALUE, 4'd11: log2 tile code that counts as a win (11 = 2048).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  new-game pulse; accepted only in IDLE or OVER
- move_req  in  1  move request pulse; accepted only in WAIT_MOVE
- move_dir  in  2  direction d; maps to ready bit d and done bit d
- board_state  in  64  board total_current_state; cell i = [4i+3:4i], 0 = empty
- board_done  in  4  per-direction one-cycle completion pulses from board
- board_movable  in  1  board reports at least one legal merge/slide
- ready_to_board  out  4  one-hot move command, drives board ready_from_global
- preset_ext  out  1  one-cycle tile write strobe
- preset_location  out  4  cell index for the tile write
- preset_value  out  4  tile code: 1 (=2) or 2 (=4)
- busy  out  1  high in every state except IDLE, WAIT_MOVE, OVER
- won  out  1  sticky; set when any cell equals WIN_VALUE
- game_over  out  1  sticky; no empty cell and !board_movable
- timeout_err  out  1  sticky; board_done not seen within DONE_TIMEOUT

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; LFSR = LFSR_SEED; counters 0.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every cycle out of reset.
- States: IDLE, SCAN, SPAWN, SETTLE, WAIT_MOVE, MOVE, WAIT_DONE, CHECK, OVER.
- IDLE
  - On start: clear won, game_over and timeout_err.
  - Load spawn_cnt = START_TILES, then go to SCAN.
- SCAN
  - On entry, latch idx = lfsr[3:0] and scan_cnt = 0.
  - Each cycle test cell idx. If empty, go to SPAWN. Otherwise idx = idx+1 (wraps 15 to 0) and scan_cnt+1.
  - If scan_cnt reaches 16 with no empty cell, skip the spawn and go to CHECK.
  - Worst case 16 cycles.
- SPAWN
  - Assert preset_ext for exactly 1 cycle.
  - preset_location = idx.
  - preset_value = 2 if lfsr[3:0] == 0, else 1.
  - Location and value are valid in the same cycle as preset_ext; all three are 0 otherwise.
  - Next state: SETTLE.
- SETTLE
  - 1 cycle, so the board registers the tile before the next read.
  - spawn_cnt decrements. If it is still nonzero, go to SCAN; else go to CHECK.
- WAIT_MOVE
  - Idle, busy=0.
  - On move_req: snapshot board_state, latch d = move_dir, go to MOVE.
- MOVE
  - Drive ready_to_board = 1<<d. Clear the timeout counter.
  - Next state: WAIT_DONE.
- WAIT_DONE
  - Hold ready_to_board = 1<<d.
  - On board_done[d]: drop ready_to_board to 0 next cycle and go to CHECK_CHANGE.
    - If board_state differs from the snapshot: spawn_cnt = 1, go to SCAN.
    - Else go to CHECK (illegal move, no spawn).
  - board_done bits other than d are ignored.
  - If the counter reaches DONE_TIMEOUT: set timeout_err, drop ready_to_board, go to WAIT_MOVE without spawning.
- CHECK (1 cycle)
  - won |= any cell == WIN_VALUE.
  - If no cell == 0 and board_movable == 0: set game_over, go to OVER. Else go to WAIT_MOVE.
- OVER
  - Outputs hold.
  - Only start (returns to the IDLE flow) or rst leaves this state.
- move_req while busy or in IDLE/OVER: dropped, no queuing.
- start outside IDLE/OVER: ignored.
- Simultaneous start and move_req in WAIT_MOVE: move_req wins; start is ignored.
- rst mid-operation: abort immediately. preset_ext and ready_to_board drop asynchronously.
- The board is not cleared by this block. The top level pulses the board reset together with start.

Decomposition:
- Shared package game_pkg holds:
  - direction constants DIR_0..DIR_3 (bit index into ready/done);
  - TILE_EMPTY = 4'd0, TILE_2 = 4'd1, TILE_4 = 4'd2, WIN code;
  - state enum encoding;
  - LFSR mask 16'hB400.
- Sub-module lfsr16 (seed parameter, free-running, 16-bit output), reusable for other randomness.
- The empty-cell scan stays inline.

Test Plan:
- Reset/start: rst high then low. Pulse start with an empty board model and LFSR_SEED=16'hACE1.
  - Exactly 2 preset_ext pulses, each 1 cycle, at distinct locations; first location = seed-derived idx.
  - Ends in WAIT_MOVE with busy=0.
- Legal move: move_req with move_dir=2. Board model returns board_done[2] 3 cycles later with a changed state.
  - ready_to_board = 4'b0100 from MOVE until the done cycle, then 0.
  - One spawn follows; game_over stays 0.
- Illegal move: board_done[1] arrives with an unchanged state.
  - No preset_ext pulse; returns to WAIT_MOVE.
- Wraparound scan: only cell 3 is empty and lfsr[3:0]=5.
  - preset_location=3 after a 15-cell scan.
- Full board and game over: all cells nonzero, board_movable=0, move changes state but no empty cell remains.
  - No spawn; game_over=1; state OVER; further move_req ignored.
- Timeout and win:
  - Withhold board_done for 255 cycles → timeout_err=1, ready_to_board=0, back in WAIT_MOVE.
  - A later move producing a cell of 4'd11 → won=1 in CHECK.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the game controller.
package game_pkg;

  // Bit index into ready_to_board / board_done for each move direction.
  localparam int DIR_0 = 0;
  localparam int DIR_1 = 1;
  localparam int DIR_2 = 2;
  localparam int DIR_3 = 3;

  localparam int NUM_CELLS = 16;

  // Tile codes are log2 of the face value; 0 marks an empty cell.
  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_2     = 4'd1;
  localparam logic [3:0] TILE_4     = 4'd2;
  localparam logic [3:0] TILE_WIN   = 4'd11;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SPAWN,
    ST_SETTLE,
    ST_WAIT_MOVE,
    ST_MOVE,
    ST_WAIT_DONE,
    ST_CHECK_CHANGE,
    ST_CHECK,
    ST_OVER
  } state_t;

  function automatic logic [3:0] cell_at(input logic [63:0] board, input logic [3:0] idx);
    return board[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    case (int'(d))
      DIR_0:   return 4'b0001;
      DIR_1:   return 4'b0010;
      DIR_2:   return 4'b0100;
      DIR_3:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// Free-running 16-bit Galois LFSR; SEED must be nonzero or the sequence sticks at 0.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (value[0]) begin
      value <= (value >> 1) ^ MASK;
    end else begin
      value <= value >> 1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Move/spawn sequencer for the 16-cell board: issues one-hot moves, waits for
// board_done, spawns tiles into empty cells and tracks win / game-over / timeout.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          START_TILES  = 2,
  parameter int          DONE_TIMEOUT = 255,
  parameter logic [3:0]  WIN_VALUE    = TILE_WIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_req,
  input  logic [1:0]  move_dir,
  input  logic [63:0] board_state,
  input  logic [3:0]  board_done,
  input  logic        board_movable,
  output logic [3:0]  ready_to_board,
  output logic        preset_ext,
  output logic [3:0]  preset_location,
  output logic [3:0]  preset_value,
  output logic        busy,
  output logic        won,
  output logic        game_over,
  output logic        timeout_err
);

  localparam int SPAWN_W = (START_TILES > 1) ? $clog2(START_TILES + 1) : 1;
  localparam int TO_W    = $clog2(DONE_TIMEOUT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         lfsr;
  logic [3:0]          idx;
  logic [4:0]          scan_cnt;
  logic [SPAWN_W-1:0]  spawn_cnt;
  logic [SPAWN_W-1:0]  spawn_cnt_dec;
  logic [63:0]         snapshot;
  logic [1:0]          dir;
  logic [TO_W-1:0]     to_cnt;
  logic                has_empty;
  logic                has_win;
  logic                cur_empty;
  logic                done_hit;
  logic                to_expired;
  logic                board_changed;
  logic                scan_exhausted;
  logic                unused_lfsr_bits;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Only the low nibble feeds placement; the rest is kept for wider reuse.
  assign unused_lfsr_bits = ^lfsr[15:4];

  always_comb begin
    // NOTE: every variable driven in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    has_empty = 1'b0;
    has_win   = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (board_state[4*i +: 4] == TILE_EMPTY) has_empty = 1'b1;
      if (board_state[4*i +: 4] == WIN_VALUE)  has_win   = 1'b1;
    end
  end

  assign cur_empty      = (cell_at(board_state, idx) == TILE_EMPTY);
  assign done_hit       = board_done[dir];
  assign to_expired     = (to_cnt == TO_W'(DONE_TIMEOUT - 1));
  assign board_changed  = (board_state != snapshot);
  assign scan_exhausted = ((scan_cnt + 5'd1) == 5'(NUM_CELLS));
  assign spawn_cnt_dec  = spawn_cnt - SPAWN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // CHECK_CHANGE gives the board one cycle after its done pulse to present the
  // post-move state before it is compared with the snapshot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_OVER: if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (cur_empty)           state_nxt = ST_SPAWN;
        else if (scan_exhausted) state_nxt = ST_CHECK;
      end
      ST_SPAWN:        state_nxt = ST_SETTLE;
      ST_SETTLE:       state_nxt = (spawn_cnt_dec != '0) ? ST_SCAN : ST_CHECK;
      ST_WAIT_MOVE:    if (move_req) state_nxt = ST_MOVE;
      ST_MOVE:         state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_hit)        state_nxt = ST_CHECK_CHANGE;
        else if (to_expired) state_nxt = ST_WAIT_MOVE;
      end
      ST_CHECK_CHANGE: state_nxt = board_changed ? ST_SCAN : ST_CHECK;
      ST_CHECK:        state_nxt = (!has_empty && !board_movable) ? ST_OVER : ST_WAIT_MOVE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      scan_cnt    <= '0;
      spawn_cnt   <= '0;
      snapshot    <= '0;
      dir         <= '0;
      to_cnt      <= '0;
      won         <= 1'b0;
      game_over   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            won         <= 1'b0;
            game_over   <= 1'b0;
            timeout_err <= 1'b0;
            spawn_cnt   <= SPAWN_W'(START_TILES);
          end
        end
        ST_SCAN: begin
          if (!cur_empty) begin
            idx      <= idx + 4'd1;
            scan_cnt <= scan_cnt + 5'd1;
          end
        end
        ST_SETTLE:    spawn_cnt <= spawn_cnt_dec;
        ST_WAIT_MOVE: begin
          if (move_req) begin
            snapshot <= board_state;
            dir      <= move_dir;
          end
        end
        ST_MOVE:      to_cnt <= '0;
        ST_WAIT_DONE: begin
          if (!done_hit) begin
            if (to_expired) timeout_err <= 1'b1;
            else            to_cnt      <= to_cnt + TO_W'(1);
          end
        end
        ST_CHECK_CHANGE: if (board_changed) spawn_cnt <= SPAWN_W'(1);
        ST_CHECK: begin
          if (has_win)                     won       <= 1'b1;
          if (!has_empty && !board_movable) game_over <= 1'b1;
        end
        default: ;
      endcase

      // Each scan starts from a fresh random cell; later assignment wins on entry.
      if (state != ST_SCAN && state_nxt == ST_SCAN) begin
        idx      <= lfsr[3:0];
        scan_cnt <= '0;
      end
    end
  end

  always_comb begin
    ready_to_board  = '0;
    preset_ext      = 1'b0;
    preset_location = '0;
    preset_value    = '0;
    busy            = 1'b1;
    unique case (state)
      ST_IDLE, ST_WAIT_MOVE, ST_OVER: busy = 1'b0;
      ST_MOVE, ST_WAIT_DONE:          ready_to_board = dir_onehot(dir);
      ST_SPAWN: begin
        preset_ext      = 1'b1;
        preset_location = idx;
        preset_value    = (lfsr[3:0] == 4'd0) ? TILE_4 : TILE_2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a board model answers moves and a scoreboard
// checks every spawn (location, value, cycle) against predictions from the stimulus.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        move_req = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic [63:0] board;
  logic [3:0]  board_done = 4'd0;
  logic        board_movable = 1'b1;
  logic [3:0]  ready_to_board;
  logic        preset_ext;
  logic [3:0]  preset_location;
  logic [3:0]  preset_value;
  logic        busy;
  logic        won;
  logic        game_over;
  logic        timeout_err;

  logic        load_req = 1'b0;
  logic [63:0] load_val = '0;
  logic [15:0] lfsr_m;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_preset;

  typedef struct {
    logic [3:0] loc;
    logic [3:0] val;
    int         cyc;
  } spawn_t;

  spawn_t exp_q[$];

  game_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .move_req        (move_req),
    .move_dir        (move_dir),
    .board_state     (board),
    .board_done      (board_done),
    .board_movable   (board_movable),
    .ready_to_board  (ready_to_board),
    .preset_ext      (preset_ext),
    .preset_location (preset_location),
    .preset_value    (preset_value),
    .busy            (busy),
    .won             (won),
    .game_over       (game_over),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
    logic [15:0] v = x;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // Board model: takes tile writes from the DUT, whole-board loads from stimulus.
  always @(posedge clk or posedge rst) begin
    if (rst)             board <= '0;
    else if (preset_ext) board[{preset_location, 2'b00} +: 4] <= preset_value;
    else if (load_req)   board <= load_val;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m <= 16'hACE1;
      cyc    <= 0;
    end else begin
      lfsr_m <= lfsr_step(lfsr_m);
      cyc    <= cyc + 1;
    end
  end

  // Monitor: each preset_ext pulse consumes one expected spawn.
  always @(negedge clk) begin
    spawn_t e;
    if (!rst) begin
      if (preset_ext) begin
        n_vec++;
        if (prev_preset) begin
          n_err++;
          $display("FAIL preset_width: strobe high 2+ cycles at cycle %0d, required 1", cyc);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_spawn: loc %0d val %0d at cycle %0d, required none",
                   preset_location, preset_value, cyc);
        end else begin
          e = exp_q.pop_front();
          if (preset_location !== e.loc || preset_value !== e.val || cyc != e.cyc) begin
            n_err++;
            $display("FAIL spawn: got loc %0d val %0d cycle %0d, required loc %0d val %0d cycle %0d",
                     preset_location, preset_value, cyc, e.loc, e.val, e.cyc);
          end
        end
      end
      prev_preset <= preset_ext;
    end else begin
      prev_preset <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Predict the spawns of a scan sequence entered at cycle t with LFSR value l.
  task automatic push_spawns(input logic [63:0] b, input logic [15:0] l, input int t, input int n);
    logic [63:0] bb;
    logic [15:0] lc;
    logic [15:0] ls;
    logic [15:0] lsp;
    logic [3:0]  idx0;
    logic [3:0]  c;
    int          tc;
    bit          found;
    spawn_t      item;
    bb = b;
    lc = l;
    tc = t;
    for (int s = 0; s < n; s++) begin
      found = 1'b0;
      idx0  = lc[3:0];
      ls    = lfsr_step(lc);
      for (int k = 0; k < 16 && !found; k++) begin
        c = idx0 + 4'(k);
        if (bb[{c, 2'b00} +: 4] == 4'd0) begin
          lsp      = lfsr_step(ls);
          item.loc = c;
          item.val = (lsp[3:0] == 4'd0) ? 4'd2 : 4'd1;
          item.cyc = tc + 2 + k;
          exp_q.push_back(item);
          bb[{c, 2'b00} +: 4] = item.val;
          lc    = lfsr_step(lsp);
          tc    = tc + 3 + k;
          found = 1'b1;
        end else begin
          ls = lfsr_step(ls);
        end
      end
      if (!found) break;
    end
  endtask

  task automatic do_start(input logic [63:0] nb);
    start    = 1'b1;
    load_val = nb;
    load_req = 1'b1;
    push_spawns(nb, lfsr_m, cyc, 2);
    @(negedge clk);
    start    = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Move with board_done[d] three cycles after the request; a stray done on
  // the other lines is raised one cycle earlier and must be ignored.
  task automatic move_done(input logic [1:0] d, input logic [63:0] nb, input bit changed,
                           input bit with_start, input string tag);
    logic [3:0] oh;
    oh       = 4'b0001 << d;
    move_req = 1'b1;
    move_dir = d;
    start    = with_start;
    @(negedge clk);
    move_req = 1'b0;
    start    = 1'b0;
    check({tag, "_ready_move"}, ready_to_board, oh);
    check({tag, "_busy_move"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_ready_wait"}, ready_to_board, oh);
    board_done = ~oh;
    @(negedge clk);
    board_done = oh;
    check({tag, "_ready_done"}, ready_to_board, oh);
    if (changed) begin
      load_val = nb;
      load_req = 1'b1;
      push_spawns(nb, lfsr_step(lfsr_m), cyc + 1, 1);
    end
    @(negedge clk);
    board_done = 4'd0;
    load_req   = 1'b0;
    check({tag, "_ready_drop"}, ready_to_board, 4'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [15:0] l4;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready_to_board, 4'd0);
    check("rst_preset", {preset_ext, preset_location, preset_value}, 9'd0);
    check("rst_flags", {busy, won, game_over, timeout_err}, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Start on an empty board: two seeded spawns; a move_req while busy is dropped
    do_start(64'd0);
    move_req = 1'b1;
    move_dir = 2'd1;
    @(negedge clk);
    move_req = 1'b0;
    check("start_busy_move_dropped", ready_to_board, 4'd0);
    wait_idle("start");
    check("start_spawns_done", exp_q.size(), 0);
    check("start_flags", {won, game_over, timeout_err}, 3'd0);

    // Legal move, direction 2, board changes -> one spawn
    repeat (3) @(negedge clk);
    move_done(2'd2, 64'h0000_0000_0000_0003, 1'b1, 1'b0, "legal");
    wait_idle("legal");
    check("legal_spawns_done", exp_q.size(), 0);
    check("legal_game_over", game_over, 1'b0);

    // Illegal move, direction 1, unchanged board, start raised with move_req
    repeat (2) @(negedge clk);
    move_done(2'd1, 64'd0, 1'b0, 1'b1, "illegal");
    wait_idle("illegal");
    check("illegal_no_spawn", exp_q.size(), 0);

    // Wraparound: only cell 3 empty, scan starts at cell 5
    n  = 0;
    l4 = lfsr_adv(lfsr_m, 4);
    while (l4[3:0] != 4'd5 && n < 2000) begin
      @(negedge clk);
      n++;
      l4 = lfsr_adv(lfsr_m, 4);
    end
    if (n >= 2000) begin
      n_err++;
      $display("FAIL wrap_align: lfsr nibble 5 not reached, required within 2000 cycles");
    end
    move_done(2'd0, 64'h1111_1111_1111_0111, 1'b1, 1'b0, "wrap");
    wait_idle("wrap");
    check("wrap_spawns_done", exp_q.size(), 0);
    check("wrap_cell3_filled", board[15:12] != 4'd0, 1'b1);
    check("wrap_game_over", game_over, 1'b0);

    // Timeout: board_done withheld on direction 3
    move_req = 1'b1;
    move_dir = 2'd3;
    @(negedge clk);
    move_req = 1'b0;
    repeat (199) @(negedge clk);
    check("to_ready_held", ready_to_board, 4'b1000);
    check("to_not_yet", timeout_err, 1'b0);
    repeat (100) @(negedge clk);
    check("to_err", timeout_err, 1'b1);
    check("to_ready_drop", ready_to_board, 4'd0);
    check("to_busy", busy, 1'b0);
    check("to_won", won, 1'b0);

    // Win: move produces a cell of code 11
    move_done(2'd0, 64'h0000_0000_0000_00B0, 1'b1, 1'b0, "win");
    wait_idle("win");
    check("win_spawns_done", exp_q.size(), 0);
    check("win_flag", won, 1'b1);
    check("win_to_sticky", timeout_err, 1'b1);
    check("win_game_over", game_over, 1'b0);

    // Full board, no legal move: no spawn, game over
    board_movable = 1'b0;
    move_done(2'd1, 64'h2222_2222_2222_2222, 1'b1, 1'b0, "over");
    wait_idle("over");
    check("over_no_spawn", exp_q.size(), 0);
    check("over_flag", game_over, 1'b1);
    move_req = 1'b1;
    move_dir = 2'd2;
    @(negedge clk);
    move_req = 1'b0;
    check("over_move_ignored", ready_to_board, 4'd0);
    @(negedge clk);
    check("over_hold", {busy, ready_to_board, game_over}, {1'b0, 4'd0, 1'b1});

    // Restart from OVER on a cleared board
    board_movable = 1'b1;
    do_start(64'd0);
    wait_idle("restart");
    check("restart_spawns_done", exp_q.size(), 0);
    check("restart_flags", {won, game_over, timeout_err}, 3'd0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
